// File: rtl/button_push_classifier_pkg.sv
// rtl/button_push_classifier_pkg.sv - shared types and 50 MHz defaults for the push-button classifier
package button_push_classifier_pkg;

    localparam int unsigned CNT_W               = 28;
    localparam int unsigned DEF_DEBOUNCE_CYCLES = 1_000_000;
    localparam int unsigned DEF_LONG_CYCLES     = 50_000_000;

    typedef enum logic [1:0] {
        REG_CTRL_NOP = 2'd0,
        REG_CTRL_CLR = 2'd1,
        REG_CTRL_INC = 2'd2
    } reg_ctrl_e;

    typedef enum logic [2:0] {
        ST_IDLE             = 3'd0,
        ST_PRESS_DEBOUNCE   = 3'd1,
        ST_HELD             = 3'd2,
        ST_LONG_HELD        = 3'd3,
        ST_RELEASE_DEBOUNCE = 3'd4
    } state_e;

endpackage

// File: rtl/button_push_classifier_register.sv
// rtl/button_push_classifier_register.sv - counter register with clear/increment/hold control
module button_push_classifier_register
    import button_push_classifier_pkg::*;
#(
    parameter int unsigned WIDTH = CNT_W
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  reg_ctrl_e        i_ctrl,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_q <= '0;
        end else begin
            case (i_ctrl)
                REG_CTRL_CLR: r_q <= '0;
                REG_CTRL_INC: r_q <= r_q + {{(WIDTH-1){1'b0}}, 1'b1};
                default:      r_q <= r_q;
            endcase
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/button_push_classifier.sv
// rtl/button_push_classifier.sv - debounces a raw push-button and classifies each press as short or long
module button_push_classifier
    import button_push_classifier_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES   = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned LONG_CYCLES       = DEF_LONG_CYCLES,
    parameter bit          BUTTON_ACTIVE_LOW = 1'b1
) (
    input  logic clk,
    input  logic async_reset,
    input  logic button_raw,
    output logic short_button_push,
    output logic long_button_push,
    output logic button_pressed
);

    localparam logic             IDLE_LEVEL = BUTTON_ACTIVE_LOW;
    localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LONG_LAST  = CNT_W'(LONG_CYCLES - 1);

    logic       r_sync1;
    logic       r_sync2;
    state_e     r_state;
    logic       r_long_sent;
    logic       r_short;
    logic       r_long;

    logic             w_p;
    logic [CNT_W-1:0] w_cnt;
    reg_ctrl_e        w_ctrl;
    state_e           w_state_nxt;
    logic             w_long_sent_nxt;
    logic             w_short_nxt;
    logic             w_long_nxt;

    // Synchroniser resets to the released level so a held button must re-debounce.
    always_ff @(posedge clk or negedge async_reset) begin
        if (!async_reset) begin
            r_sync1 <= IDLE_LEVEL;
            r_sync2 <= IDLE_LEVEL;
        end else begin
            r_sync1 <= button_raw;
            r_sync2 <= r_sync1;
        end
    end

    assign w_p = r_sync2 ^ IDLE_LEVEL;

    button_push_classifier_register #(
        .WIDTH (CNT_W)
    ) u_cnt (
        .i_clk   (clk),
        .i_rst_n (async_reset),
        .i_ctrl  (w_ctrl),
        .o_q     (w_cnt)
    );

    always_comb begin
        w_state_nxt     = r_state;
        w_ctrl          = REG_CTRL_NOP;
        w_long_sent_nxt = r_long_sent;
        w_short_nxt     = 1'b0;
        w_long_nxt      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_p) begin
                    w_state_nxt = ST_PRESS_DEBOUNCE;
                    w_ctrl      = REG_CTRL_CLR;
                end
            end
            ST_PRESS_DEBOUNCE: begin
                if (!w_p) begin
                    w_state_nxt = ST_IDLE;
                    w_ctrl      = REG_CTRL_CLR;
                end else if (w_cnt == DEB_LAST) begin
                    w_state_nxt = ST_HELD;
                    w_ctrl      = REG_CTRL_CLR;
                end else begin
                    w_ctrl      = REG_CTRL_INC;
                end
            end
            ST_HELD: begin
                if (!w_p) begin
                    w_state_nxt     = ST_RELEASE_DEBOUNCE;
                    w_ctrl          = REG_CTRL_CLR;
                    w_long_sent_nxt = 1'b0;
                end else if (w_cnt == LONG_LAST) begin
                    w_state_nxt     = ST_LONG_HELD;
                    w_ctrl          = REG_CTRL_CLR;
                    w_long_nxt      = 1'b1;
                    w_long_sent_nxt = 1'b1;
                end else begin
                    w_ctrl          = REG_CTRL_INC;
                end
            end
            ST_LONG_HELD: begin
                if (!w_p) begin
                    w_state_nxt = ST_RELEASE_DEBOUNCE;
                    w_ctrl      = REG_CTRL_CLR;
                end
            end
            ST_RELEASE_DEBOUNCE: begin
                // A release bounce resumes the hold with a fresh count.
                if (w_p) begin
                    w_state_nxt = r_long_sent ? ST_LONG_HELD : ST_HELD;
                    w_ctrl      = REG_CTRL_CLR;
                end else if (w_cnt == DEB_LAST) begin
                    w_state_nxt     = ST_IDLE;
                    w_ctrl          = REG_CTRL_CLR;
                    w_short_nxt     = !r_long_sent;
                    w_long_sent_nxt = 1'b0;
                end else begin
                    w_ctrl          = REG_CTRL_INC;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_ctrl      = REG_CTRL_CLR;
            end
        endcase
    end

    always_ff @(posedge clk or negedge async_reset) begin
        if (!async_reset) begin
            r_state     <= ST_IDLE;
            r_long_sent <= 1'b0;
            r_short     <= 1'b0;
            r_long      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_long_sent <= w_long_sent_nxt;
            r_short     <= w_short_nxt;
            r_long      <= w_long_nxt;
        end
    end

    assign short_button_push = r_short;
    assign long_button_push  = r_long;
    assign button_pressed    = (r_state == ST_HELD) || (r_state == ST_LONG_HELD) ||
                               (r_state == ST_RELEASE_DEBOUNCE);

endmodule

// File: tb/tb_button_push_classifier.sv
// tb/tb_button_push_classifier.sv - self-checking bench for button_push_classifier
module tb_button_push_classifier;

    localparam int D = 4;
    localparam int L = 20;

    logic clk         = 1'b0;
    logic async_reset = 1'b1;
    logic button_raw  = 1'b1;
    logic short_button_push;
    logic long_button_push;
    logic button_pressed;

    int checks = 0;
    int errors = 0;

    button_push_classifier #(
        .DEBOUNCE_CYCLES   (D),
        .LONG_CYCLES       (L),
        .BUTTON_ACTIVE_LOW (1'b1)
    ) dut (
        .clk               (clk),
        .async_reset       (async_reset),
        .button_raw        (button_raw),
        .short_button_push (short_button_push),
        .long_button_push  (long_button_push),
        .button_pressed    (button_pressed)
    );

    always #5 clk = ~clk;

    // Reference model: run lengths of the synchronised pressed level.
    bit m_s1, m_s2, m_deb, m_long_sent, m_exp_short, m_exp_long;
    int m_r1, m_r0, m_need;

    int edge_cnt = 0;
    int dut_short_n = 0, dut_long_n = 0, mod_short_n = 0, mod_long_n = 0;
    int last_short_edge = -1, last_long_edge = -1, last_fall_edge = -1;
    int cyc_err = 0, both_high = 0, pressed_cycles = 0;
    bit prev_pressed = 0;

    task automatic model_reset();
        m_s1 = 1; m_s2 = 1; m_deb = 0; m_long_sent = 0;
        m_exp_short = 0; m_exp_long = 0;
        m_r1 = 0; m_r0 = 0; m_need = 0;
        prev_pressed = 0;
    endtask

    task automatic model_edge(input bit raw);
        bit p;
        p = !m_s2;
        m_s2 = m_s1;
        m_s1 = raw;
        m_exp_short = 0;
        m_exp_long  = 0;
        if (p) begin m_r1++; m_r0 = 0; end
        else   begin m_r0++; m_r1 = 0; end
        if (!m_deb) begin
            if (p && m_r1 == D + 1) begin
                m_deb  = 1;
                m_need = D + 1 + L;
            end
        end else if (p) begin
            if (!m_long_sent && m_r1 == m_need) begin
                m_exp_long  = 1;
                m_long_sent = 1;
            end
        end else begin
            if (m_r0 == D + 1) begin
                m_deb       = 0;
                m_exp_short = !m_long_sent;
                m_long_sent = 0;
            end else begin
                m_need = L + 1;
            end
        end
    endtask

    task automatic step(input logic raw);
        button_raw = raw;
        @(posedge clk);
        edge_cnt++;
        model_edge(raw);
        @(negedge clk);
        if (short_button_push) begin dut_short_n++; last_short_edge = edge_cnt; end
        if (long_button_push)  begin dut_long_n++;  last_long_edge  = edge_cnt; end
        if (m_exp_short) mod_short_n++;
        if (m_exp_long)  mod_long_n++;
        if (short_button_push && long_button_push) both_high++;
        if (button_pressed) pressed_cycles++;
        if (prev_pressed && !button_pressed) last_fall_edge = edge_cnt;
        prev_pressed = button_pressed;
        if ({short_button_push, long_button_push, button_pressed} !==
            {m_exp_short, m_exp_long, m_deb})
            cyc_err++;
    endtask

    task automatic hold(input logic raw, input int n);
        for (int i = 0; i < n; i++) step(raw);
    endtask

    task automatic test_reset();
        int e0, err0;
        #2 async_reset = 1'b0;
        @(negedge clk); @(negedge clk);
        async_reset = 1'b1;
        model_reset();
        err0 = cyc_err;
        hold(1, 4);
        hold(0, 12);
        checks++;
        if (button_pressed !== 1'b1) begin
            errors++; $display("FAIL reset_pre_pressed: got %b want 1", button_pressed);
        end
        #2 async_reset = 1'b0;
        #1;
        checks++;
        if ({short_button_push, long_button_push, button_pressed} !== 3'b000) begin
            errors++;
            $display("FAIL reset_outputs_async: got %b%b%b want 000",
                     short_button_push, long_button_push, button_pressed);
        end
        @(negedge clk); @(negedge clk); @(negedge clk);
        async_reset = 1'b1;
        model_reset();
        e0 = edge_cnt + 1;
        hold(0, 6);
        checks++;
        if (button_pressed !== 1'b0) begin
            errors++; $display("FAIL reset_pressed_edge5: got %b want 0", button_pressed);
        end
        step(0);
        checks++;
        if (button_pressed !== 1'b1 || edge_cnt != e0 + 6) begin
            errors++;
            $display("FAIL reset_pressed_edge6: got %b at edge %0d want 1 at edge %0d",
                     button_pressed, edge_cnt, e0 + 6);
        end
        hold(1, 12);
        checks++;
        if (cyc_err != err0) begin
            errors++; $display("FAIL reset_model: %0d cycle differences want 0", cyc_err - err0);
        end
    endtask

    task automatic test_short();
        int s0, l0, rel, err0;
        hold(1, 4);
        s0 = dut_short_n; l0 = dut_long_n; err0 = cyc_err;
        hold(0, 10);
        rel = edge_cnt + 1;
        hold(1, 12);
        checks++;
        if (dut_short_n - s0 != 1 || dut_long_n - l0 != 0) begin
            errors++;
            $display("FAIL short_counts: short %0d long %0d want 1 0", dut_short_n - s0, dut_long_n - l0);
        end
        checks++;
        if (last_short_edge != rel + 6) begin
            errors++; $display("FAIL short_timing: edge %0d want %0d", last_short_edge, rel + 6);
        end
        checks++;
        if (cyc_err != err0) begin
            errors++; $display("FAIL short_model: %0d cycle differences want 0", cyc_err - err0);
        end
    endtask

    task automatic test_long();
        int s0, l0, pr, rel, err0;
        hold(1, 4);
        s0 = dut_short_n; l0 = dut_long_n; err0 = cyc_err;
        pr = edge_cnt + 1;
        hold(0, 40);
        checks++;
        if (dut_long_n - l0 != 1 || last_long_edge != pr + 26) begin
            errors++;
            $display("FAIL long_strobe: count %0d at edge %0d want 1 at edge %0d",
                     dut_long_n - l0, last_long_edge, pr + 26);
        end
        rel = edge_cnt + 1;
        hold(1, 12);
        checks++;
        if (dut_short_n - s0 != 0) begin
            errors++; $display("FAIL long_no_short: short count %0d want 0", dut_short_n - s0);
        end
        checks++;
        if (last_fall_edge != rel + 6) begin
            errors++; $display("FAIL long_release_fall: edge %0d want %0d", last_fall_edge, rel + 6);
        end
        checks++;
        if (cyc_err != err0) begin
            errors++; $display("FAIL long_model: %0d cycle differences want 0", cyc_err - err0);
        end
    endtask

    task automatic test_glitch();
        int s0, l0, pc0;
        hold(1, 4);
        s0 = dut_short_n; l0 = dut_long_n; pc0 = pressed_cycles;
        hold(0, 3);
        hold(1, 10);
        checks++;
        if (dut_short_n != s0 || dut_long_n != l0 || pressed_cycles != pc0) begin
            errors++;
            $display("FAIL glitch_reject: short %0d long %0d pressed cycles %0d want 0 0 0",
                     dut_short_n - s0, dut_long_n - l0, pressed_cycles - pc0);
        end
        hold(0, 5);
        hold(1, 1);
        hold(0, 4);
        hold(1, 12);
        checks++;
        if (dut_short_n - s0 != 1 || dut_long_n != l0) begin
            errors++;
            $display("FAIL glitch_in_hold: short %0d long %0d want 1 0", dut_short_n - s0, dut_long_n - l0);
        end
    endtask

    task automatic test_threshold();
        int s0, l0;
        hold(1, 4);
        s0 = dut_short_n; l0 = dut_long_n;
        hold(0, D + L);
        hold(1, 12);
        checks++;
        if (dut_short_n - s0 != 1 || dut_long_n - l0 != 0) begin
            errors++;
            $display("FAIL threshold_below: short %0d long %0d want 1 0", dut_short_n - s0, dut_long_n - l0);
        end
        s0 = dut_short_n; l0 = dut_long_n;
        hold(0, D + L + 1);
        hold(1, 12);
        checks++;
        if (dut_short_n - s0 != 0 || dut_long_n - l0 != 1) begin
            errors++;
            $display("FAIL threshold_at: short %0d long %0d want 0 1", dut_short_n - s0, dut_long_n - l0);
        end
    endtask

    task automatic test_reset_mid_hold();
        int s0, l0, rr;
        hold(1, 8);
        s0 = dut_short_n; l0 = dut_long_n;
        hold(0, 15);
        #2 async_reset = 1'b0;
        #1;
        checks++;
        if (button_pressed !== 1'b0) begin
            errors++; $display("FAIL midhold_reset_pressed: got %b want 0", button_pressed);
        end
        @(negedge clk); @(negedge clk);
        async_reset = 1'b1;
        model_reset();
        rr = edge_cnt + 1;
        hold(0, 30);
        checks++;
        if (dut_long_n - l0 != 1 || last_long_edge != rr + 26 || dut_short_n != s0) begin
            errors++;
            $display("FAIL midhold_long: long %0d at edge %0d short %0d want 1 at %0d short 0",
                     dut_long_n - l0, last_long_edge, dut_short_n - s0, rr + 26);
        end
        hold(1, 12);
        checks++;
        if (dut_short_n != s0) begin
            errors++; $display("FAIL midhold_release: short %0d want 0", dut_short_n - s0);
        end
    endtask

    task automatic test_random();
        int err0, ms0, ml0, ds0, dl0, dur;
        logic lvl;
        hold(1, 8);
        err0 = cyc_err;
        ms0 = mod_short_n; ml0 = mod_long_n; ds0 = dut_short_n; dl0 = dut_long_n;
        lvl = 1'b0;
        for (int seg = 0; seg < 300; seg++) begin
            case ($urandom_range(0, 3))
                0:       dur = $urandom_range(1, 3);
                1:       dur = $urandom_range(4, 7);
                2:       dur = $urandom_range(8, 18);
                default: dur = $urandom_range(20, 30);
            endcase
            hold(lvl, dur);
            lvl = ~lvl;
        end
        hold(1, 12);
        checks++;
        if (cyc_err != err0) begin
            errors++; $display("FAIL random_cycles: %0d cycle differences want 0", cyc_err - err0);
        end
        checks++;
        if (dut_short_n - ds0 != mod_short_n - ms0 || dut_long_n - dl0 != mod_long_n - ml0) begin
            errors++;
            $display("FAIL random_counts: short %0d long %0d want %0d %0d",
                     dut_short_n - ds0, dut_long_n - dl0, mod_short_n - ms0, mod_long_n - ml0);
        end
        checks++;
        if (both_high != 0) begin
            errors++; $display("FAIL strobes_exclusive: %0d cycles both high want 0", both_high);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_short();
        test_long();
        test_glitch();
        test_threshold();
        test_reset_mid_hold();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
